// File: rtl/capture_ctrl_n_if.sv
// Capture/dump bundle between capture_ctrl_n, the trigger and command blocks, and the shared capture RAM.
interface capture_ctrl_n_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                     cap_start;
  logic [ADDR_W-1:0]        trig_pos;
  logic [3:0]               decim;
  logic                     trigger;
  logic                     armed;
  logic                     capture_done;
  logic                     en;
  logic                     we;
  logic [ADDR_W-1:0]        addr;
  logic [NUM_CH*DATA_W-1:0] rdata;
  logic                     dump_start;
  logic [CH_W-1:0]          dump_ch;
  logic [DATA_W-1:0]        dump_data;
  logic                     dump_valid;
  logic                     dump_ready;
  logic                     dump_last;
  logic                     dump_finished;

  modport slave (
    input  cap_start, trig_pos, decim, trigger, rdata, dump_start, dump_ch, dump_ready,
    output armed, capture_done, en, we, addr, dump_data, dump_valid, dump_last, dump_finished
  );

  modport master (
    output cap_start, trig_pos, decim, trigger, rdata, dump_start, dump_ch, dump_ready,
    input  armed, capture_done, en, we, addr, dump_data, dump_valid, dump_last, dump_finished
  );
endinterface

// File: rtl/capture_ctrl_n.sv
// N-channel capture sequencer: circular pre-trigger fill, post-trigger capture, valid/ready channel dump.
// Optional trailing checksum item on dumps when DUMP_CHKSUM_EN is defined.
module capture_ctrl_n #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  capture_ctrl_n_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CH_W:0]   CH_LIM  = (CH_W+1)'(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE, S_DUMP_RD, S_DUMP_WAIT
`ifdef DUMP_CHKSUM_EN
    , S_DUMP_SUM
`endif
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_wptr, r_fill, r_trig_pos, r_trace, r_rd_ptr;
  logic [ADDR_W:0]     r_post, r_rd_cnt;
  logic [CH_W-1:0]     r_ch;
  logic [15:0]         r_dcnt;
  logic                r_done, r_fin, r_first;
  logic [DATA_W-1:0]   r_data;

  logic                w_tick, w_run, w_ch_ok;
  logic                w_start, w_wr, w_trig, w_cap_done, w_dump_go, w_accept, w_fin;
  logic                w_en, w_we, w_valid;
  logic [ADDR_W-1:0]   w_addr;
  logic [15:0]         w_mask;
  logic [DATA_W-1:0]   w_slice, w_item, w_dump_data;

  assign w_run   = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
  assign w_mask  = ~(16'hFFFF << bus.decim);
  assign w_tick  = &(r_dcnt | ~w_mask);
  assign w_ch_ok = ({1'b0, bus.dump_ch} < CH_LIM);
  assign w_slice = bus.rdata[r_ch*DATA_W +: DATA_W];
  // RAM output is only guaranteed on the first WAIT cycle; later cycles replay the captured copy
  assign w_item  = r_first ? w_slice : r_data;

`ifdef DUMP_CHKSUM_EN
  localparam int LO_W = (DATA_W < 8) ? DATA_W : 8;
  logic [7:0] r_sum;
  logic [7:0] w_lo8;
  assign w_lo8 = 8'(w_item[LO_W-1:0]);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_wr        = 1'b0;
    w_trig      = 1'b0;
    w_cap_done  = 1'b0;
    w_dump_go   = 1'b0;
    w_accept    = 1'b0;
    w_fin       = 1'b0;
    w_en        = 1'b0;
    w_we        = 1'b0;
    w_addr      = '0;
    w_valid     = 1'b0;
    case (r_state)
      S_IDLE: if (bus.cap_start) begin
        w_start     = 1'b1;
        w_state_nxt = S_PRE;
      end
      S_PRE: begin
        if (r_fill == r_trig_pos) begin
          w_state_nxt = S_ARMED;
        end else if (w_tick) begin
          w_wr = 1'b1;
          if (r_fill + 1'b1 == r_trig_pos) w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        w_wr = w_tick;
        if (bus.trigger) begin
          w_trig      = 1'b1;
          w_state_nxt = S_POST;
        end
      end
      S_POST: if (w_tick) begin
        w_wr = 1'b1;
        if (r_post == CNT_ONE) begin
          w_cap_done  = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.cap_start) begin
          w_start     = 1'b1;
          w_state_nxt = S_PRE;
        end else if (bus.dump_start && w_ch_ok) begin
          w_dump_go   = 1'b1;
          w_state_nxt = S_DUMP_RD;
        end
      end
      S_DUMP_RD: begin
        w_en        = 1'b1;
        w_addr      = r_rd_ptr;
        w_state_nxt = S_DUMP_WAIT;
      end
      S_DUMP_WAIT: begin
        w_valid = 1'b1;
        if (bus.dump_ready) begin
          w_accept = 1'b1;
          if (r_rd_cnt == CNT_ONE) begin
`ifdef DUMP_CHKSUM_EN
            w_state_nxt = S_DUMP_SUM;
`else
            w_fin       = 1'b1;
            w_state_nxt = S_DONE;
`endif
          end else begin
            w_state_nxt = S_DUMP_RD;
          end
        end
      end
`ifdef DUMP_CHKSUM_EN
      S_DUMP_SUM: begin
        w_valid = 1'b1;
        if (bus.dump_ready) begin
          w_fin       = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_wr) begin
      w_en   = 1'b1;
      w_we   = 1'b1;
      w_addr = r_wptr;
    end
  end

  always_comb begin
    w_dump_data = '0;
    if (r_state == S_DUMP_WAIT) w_dump_data = w_item;
`ifdef DUMP_CHKSUM_EN
    else if (r_state == S_DUMP_SUM) w_dump_data = DATA_W'(r_sum);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_fill     <= '0;
      r_trig_pos <= '0;
      r_trace    <= '0;
      r_rd_ptr   <= '0;
      r_post     <= '0;
      r_rd_cnt   <= '0;
      r_ch       <= '0;
      r_dcnt     <= '0;
      r_done     <= 1'b0;
      r_fin      <= 1'b0;
      r_first    <= 1'b0;
      r_data     <= '0;
    end else begin
      r_fin   <= w_fin;
      r_first <= (r_state == S_DUMP_RD);
      if (w_start) begin
        r_fill     <= '0;
        r_trig_pos <= bus.trig_pos;
        r_dcnt     <= '0;
        r_done     <= 1'b0;
      end else if (w_run) begin
        r_dcnt <= r_dcnt + 16'd1;
      end
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
        if (r_state == S_PRE)  r_fill <= r_fill + 1'b1;
        if (r_state == S_POST) r_post <= r_post - 1'b1;
      end
      if (w_trig) r_post <= DEPTH_V - {1'b0, r_trig_pos};
      if (w_cap_done) begin
        r_trace <= r_wptr + 1'b1;
        r_done  <= 1'b1;
      end
      if (w_dump_go) begin
        r_ch     <= bus.dump_ch;
        r_rd_ptr <= r_trace;
        r_rd_cnt <= DEPTH_V;
      end
      if (r_first) r_data <= w_slice;
      if (w_accept) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_rd_cnt <= r_rd_cnt - 1'b1;
      end
    end
  end

`ifdef DUMP_CHKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_sum <= '0;
    else if (w_dump_go) r_sum <= '0;
    else if (w_accept)  r_sum <= r_sum + w_lo8;
  end
  assign bus.dump_last = (r_state == S_DUMP_SUM);
`else
  assign bus.dump_last = (r_state == S_DUMP_WAIT) && (r_rd_cnt == CNT_ONE);
`endif

  assign bus.armed         = (r_state == S_ARMED);
  assign bus.capture_done  = r_done;
  assign bus.en            = w_en;
  assign bus.we            = w_we;
  assign bus.addr          = w_addr;
  assign bus.dump_data     = w_dump_data;
  assign bus.dump_valid    = w_valid;
  assign bus.dump_finished = r_fin;
endmodule

// File: tb/tb_capture_ctrl_n.sv
// Directed bench for capture_ctrl_n: RAM model, write-order history and a dump scoreboard queue.
module tb_capture_ctrl_n;
  localparam int NUM_CH = 3;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  capture_ctrl_n_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  capture_ctrl_n #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_wr = 0;
  int n_items = 0;

  logic [7:0] mem [NUM_CH][DEPTH];
  logic [7:0] sval = 8'd0;
  logic [7:0] hist [$];
  logic [7:0] sb [$];
  logic [3:0] m_wptr = 4'd0;
  logic       pend = 1'b0;
  logic       fin_exp = 1'b0;
  logic [7:0] held = 8'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // RAM: channel c stores (write index + c*0x50)
  always @(posedge clk) begin
    if (bus.en && bus.we) begin
      for (int c = 0; c < NUM_CH; c++) mem[c][bus.addr] <= sval + 8'(c * 8'h50);
      sval <= sval + 8'd1;
    end else if (bus.en) begin
      for (int c = 0; c < NUM_CH; c++) bus.rdata[c*DATA_W +: DATA_W] <= mem[c][bus.addr];
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      m_wptr  = 4'd0;
      pend    = 1'b0;
      fin_exp = 1'b0;
    end else begin
      chk("dump_finished", bus.dump_finished, fin_exp);
      fin_exp = 1'b0;
      if (bus.en && bus.we) begin
        chk("waddr", bus.addr, m_wptr);
        hist.push_back(sval);
        m_wptr = m_wptr + 4'd1;
        n_wr++;
      end
      if (pend) chk("hold", bus.dump_data, held);
      pend = 1'b0;
      if (bus.dump_valid) begin
        chk("dump_last", bus.dump_last, sb.size() == 1);
        if (bus.dump_ready) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            chk("dump_data", bus.dump_data, sb.pop_front());
            if (sb.size() == 0) fin_exp = 1'b1;
          end
          n_items++;
        end else begin
          pend = 1'b1;
          held = bus.dump_data;
        end
      end
    end
  end

  task automatic push_exp(input int ch);
    logic [7:0] v;
    logic [7:0] sum;
    sum = 8'd0;
    for (int i = 0; i < DEPTH; i++) begin
      v = hist[hist.size() - DEPTH + i] + 8'(ch * 8'h50);
      sb.push_back(v);
      sum = sum + v;
    end
`ifdef DUMP_CHKSUM_EN
    sb.push_back(sum);
`endif
  endtask

  task automatic pulse_cap();
    @(posedge clk); #1 bus.cap_start = 1'b1;
    @(posedge clk); #1 bus.cap_start = 1'b0;
  endtask

  task automatic pulse_dump(input int ch);
    bus.dump_ch = 2'(ch);
    @(posedge clk); #1 bus.dump_start = 1'b1;
    @(posedge clk); #1 bus.dump_start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk(tag, {bus.armed, bus.capture_done, bus.en, bus.we, bus.addr, bus.dump_valid,
              bus.dump_last, bus.dump_finished, bus.dump_data}, 0);
  endtask

  task automatic wait_armed(input string tag);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (bus.armed) break;
    end
    chk(tag, bus.armed, 1);
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk); #1;
      if (bus.capture_done) break;
    end
    chk(tag, bus.capture_done, 1);
  endtask

  // mode 0: ready pattern 0,1,1 repeating; mode 1: ready held high. inj pulses cap_start mid-dump.
  task automatic run_dump(input int ch, input int mode, input bit inj);
    int base;
    base = n_items;
    push_exp(ch);
    pulse_dump(ch);
    for (int k = 0; k < 600 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
      bus.dump_ready = (mode == 1) || (k % 3 != 0);
      bus.cap_start  = inj && (k == 4);
    end
    bus.dump_ready = 1'b0;
    bus.cap_start  = 1'b0;
    @(negedge clk); #1;
    chk("dump_drained", sb.size(), 0);
`ifdef DUMP_CHKSUM_EN
    chk("dump_items", n_items - base, DEPTH + 1);
`else
    chk("dump_items", n_items - base, DEPTH);
`endif
    chk("done_after_dump", bus.capture_done, 1);
  endtask

  initial begin
    int base;
    int last;
    int cnt;
    bus.cap_start  = 1'b0;
    bus.trig_pos   = '0;
    bus.decim      = '0;
    bus.trigger    = 1'b0;
    bus.dump_start = 1'b0;
    bus.dump_ch    = '0;
    bus.dump_ready = 1'b0;
    #1 check_idle("reset_async");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1 check_idle("reset_idle");

    // 1: trig_pos=4, decim=0, trigger 3 cycles after armed
    bus.trig_pos = 4'd4;
    base = n_wr;
    pulse_cap();
    wait_armed("t1_armed");
    chk("t1_pre_writes", n_wr - base, 5);   // 4 PRE writes + first ARMED-cycle write
    repeat (3) @(posedge clk);
    #1 bus.trigger = 1'b1;
    @(posedge clk); #1 bus.trigger = 1'b0;
    #1 chk("t1_armed_post", bus.armed, 0);
    wait_done("t1_done");
    chk("t1_total_writes", n_wr - base, 20);

    // 3: dump ch2 with throttled ready
    run_dump(2, 0, 1'b0);

    // out-of-range channel is ignored
    pulse_dump(3);
    repeat (3) begin
      @(negedge clk); #1;
      chk("bad_ch_no_dump", {bus.dump_valid, bus.en}, 0);
    end
    chk("bad_ch_done", bus.capture_done, 1);

    // 2: decim=2, trigger held high through PRE
    bus.decim   = 4'd2;
    bus.trigger = 1'b1;
    base = n_wr;
    last = -1;
    cnt  = 0;
    pulse_cap();
    for (int c = 0; c < 120; c++) begin
      @(negedge clk); #1;
      if (bus.en && bus.we) begin
        if (last < 0) chk("t2_first_tick", c, 3);
        else          chk("t2_gap", c - last, 4);
        last = c;
        cnt++;
      end
      if (bus.capture_done) break;
    end
    chk("t2_writes", cnt, 16);
    chk("t2_done", bus.capture_done, 1);
    bus.trigger = 1'b0;

    // 4: trig_pos=0 with trigger already high at cap_start
    bus.decim    = 4'd0;
    bus.trig_pos = 4'd0;
    bus.trigger  = 1'b1;
    base = n_wr;
    pulse_cap();
    @(negedge clk); #1;
    chk("t4_pre_cycle", {bus.armed, bus.en}, 0);
    @(negedge clk); #1;
    chk("t4_armed", bus.armed, 1);
    wait_done("t4_done");
    chk("t4_writes", n_wr - base, 17);
    bus.trigger = 1'b0;
    run_dump(0, 0, 1'b0);

    // 5a: reset mid-POST
    bus.trig_pos = 4'd2;
    bus.decim    = 4'd1;
    bus.trigger  = 1'b1;
    pulse_cap();
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_idle("t5_reset_post");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.trigger = 1'b0;

    // restart cleanly from address 0
    bus.trig_pos = 4'd8;
    bus.decim    = 4'd0;
    base = n_wr;
    pulse_cap();
    wait_armed("t5_armed");
    chk("t5_pre_writes", n_wr - base, 9);
    bus.trigger = 1'b1;
    wait_done("t5_done");
    bus.trigger = 1'b0;
    chk("t5_writes", n_wr - base, 17);

    // 5b: reset mid-dump
    push_exp(1);
    pulse_dump(1);
    bus.dump_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_idle("t5_reset_dump");
    bus.dump_ready = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // trig_pos=DEPTH-1 boundary, then dump with a cap_start arriving mid-dump
    bus.trig_pos = 4'd15;
    base = n_wr;
    pulse_cap();
    wait_armed("t6_armed");
    bus.trigger = 1'b1;
    wait_done("t6_done");
    bus.trigger = 1'b0;
    chk("t6_writes", n_wr - base, 17);
    run_dump(1, 1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
